// File: rtl/i2c_reg_init_seq.sv
// I2C register-initialisation sequencer: writes NUM_REGS table entries as 3-byte I2C writes.
// Optional clock stretching support is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_reg_init_seq #(
    parameter int unsigned CLK_DIV   = 125,
    parameter int unsigned NUM_REGS  = 31,
    parameter int unsigned IDX_W     = 8,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned GAP_QTR   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    inout  wire              I2C_SCL,
    inout  wire              I2C_SDA,
    output logic [IDX_W-1:0] tbl_index,
    input  logic [23:0]      tbl_data,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_index
);
    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DivLast   = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IdxLast   = IDX_W'(NUM_REGS - 1);
    localparam logic [7:0]       GapLast   = 8'(GAP_QTR - 1);
    localparam logic [3:0]       RetryMax  = 4'(MAX_RETRY);

    typedef enum logic [3:0] {
        StIdle, StLoad, StStart, StByte, StAck, StStop, StGap, StAbort, StDone, StError
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       qph_q, qph_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic             ld_q, ld_d;
    logic [23:0]      sh_q, sh_d;
    logic [IDX_W-1:0] idx_q, idx_d, err_idx_q, err_idx_d;
    logic [3:0]       retry_q, retry_d;
    logic             nack_q, nack_d, restart_q, restart_d;
    logic             scl_rel_q, scl_rel_d, sda_rel_q, sda_rel_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic             sda_meta_q, sda_sync_q;
    logic             run, hold, qtick;

`ifdef I2C_CLK_STRETCH_EN
    logic scl_meta_q, scl_sync_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
        end else begin
            scl_meta_q <= I2C_SCL;
            scl_sync_q <= scl_meta_q;
        end
    end
    // Wait for a stretching slave to let SCL go high before the q2 action.
    assign hold = (state_q inside {StByte, StAck}) && (qph_q == 2'd2) && !scl_sync_q;
`else
    assign hold = 1'b0;
`endif

    assign run   = !(state_q inside {StIdle, StDone, StError});
    assign qtick = run && !hold && (div_q == DivLast);

    always_comb begin
        state_d    = state_q;
        qph_d      = qph_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        ld_d       = ld_q;
        sh_d       = sh_q;
        idx_d      = idx_q;
        err_idx_d  = err_idx_q;
        retry_d    = retry_q;
        nack_d     = nack_q;
        restart_d  = restart_q;
        scl_rel_d  = scl_rel_q;
        sda_rel_d  = sda_rel_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        if (!run) div_d = '0;
        else if (hold) div_d = div_q;
        else if (qtick) div_d = '0;
        else div_d = div_q + DIV_W'(1);

        unique case (state_q)
            StIdle, StDone, StError: ;
            StLoad: begin
                // Table may be registered: give it one clk after the index settles.
                if (!ld_q) begin
                    ld_d = 1'b1;
                end else begin
                    ld_d       = 1'b0;
                    sh_d       = tbl_data;
                    byte_cnt_d = 2'd0;
                    qph_d      = 2'd0;
                    state_d    = StStart;
                end
            end
            StStart: if (qtick) begin
                qph_d = qph_q + 2'd1;
                case (qph_q)
                    2'd0: begin scl_rel_d = 1'b1; sda_rel_d = 1'b1; end
                    2'd1: sda_rel_d = 1'b0;
                    2'd2: scl_rel_d = 1'b0;
                    default: begin bit_cnt_d = 3'd0; state_d = StByte; end
                endcase
            end
            StByte: if (qtick) begin
                qph_d = qph_q + 2'd1;
                case (qph_q)
                    2'd0: sda_rel_d = sh_q[23];
                    2'd1: scl_rel_d = 1'b1;
                    2'd2: ;
                    default: begin
                        scl_rel_d = 1'b0;
                        sh_d      = {sh_q[22:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = StAck;
                    end
                endcase
            end
            StAck: if (qtick) begin
                qph_d = qph_q + 2'd1;
                case (qph_q)
                    2'd0: sda_rel_d = 1'b1;
                    2'd1: scl_rel_d = 1'b1;
                    2'd2: nack_d = sda_sync_q;
                    default: begin
                        scl_rel_d = 1'b0;
                        if (nack_q || byte_cnt_q == 2'd2) begin
                            state_d = StStop;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            state_d    = StByte;
                        end
                    end
                endcase
            end
            StStop: if (qtick) begin
                qph_d = qph_q + 2'd1;
                case (qph_q)
                    2'd0: sda_rel_d = 1'b0;
                    2'd1: scl_rel_d = 1'b1;
                    default: begin
                        sda_rel_d = 1'b1;
                        gap_cnt_d = 8'd0;
                        qph_d     = 2'd0;
                        state_d   = StGap;
                    end
                endcase
            end
            StGap: if (qtick) begin
                gap_cnt_d = gap_cnt_q + 8'd1;
                if (gap_cnt_q == GapLast) begin
                    state_d = StLoad;
                    if (restart_q) begin
                        restart_d = 1'b0;
                    end else if (nack_q) begin
                        if (retry_q < RetryMax) begin
                            retry_d = retry_q + 4'd1;
                        end else begin
                            error_d   = 1'b1;
                            err_idx_d = idx_q;
                            busy_d    = 1'b0;
                            state_d   = StError;
                        end
                    end else if (idx_q == IdxLast) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        retry_d = 4'd0;
                    end
                end
            end
            StAbort: if (qtick) begin
                // Bring SCL low, then free SDA, so the following STOP is clean.
                if (scl_rel_q) scl_rel_d = 1'b0;
                else if (!sda_rel_q) sda_rel_d = 1'b1;
                else begin
                    qph_d   = 2'd0;
                    state_d = StStop;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            idx_d   = '0;
            retry_d = 4'd0;
            done_d  = 1'b0;
            error_d = 1'b0;
            busy_d  = 1'b1;
            nack_d  = 1'b0;
            ld_d    = 1'b0;
            if (!busy_q || state_q inside {StLoad, StGap}) begin
                restart_d = 1'b0;
                state_d   = StLoad;
            end else begin
                restart_d = 1'b1;
                qph_d     = 2'd0;
                state_d   = StAbort;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            div_q      <= '0;
            qph_q      <= 2'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            gap_cnt_q  <= 8'd0;
            ld_q       <= 1'b0;
            sh_q       <= 24'd0;
            idx_q      <= '0;
            err_idx_q  <= '0;
            retry_q    <= 4'd0;
            nack_q     <= 1'b0;
            restart_q  <= 1'b0;
            scl_rel_q  <= 1'b1;
            sda_rel_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            qph_q      <= qph_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            ld_q       <= ld_d;
            sh_q       <= sh_d;
            idx_q      <= idx_d;
            err_idx_q  <= err_idx_d;
            retry_q    <= retry_d;
            nack_q     <= nack_d;
            restart_q  <= restart_d;
            scl_rel_q  <= scl_rel_d;
            sda_rel_q  <= sda_rel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            sda_meta_q <= I2C_SDA;
            sda_sync_q <= sda_meta_q;
        end
    end

    assign I2C_SCL   = scl_rel_q ? 1'bz : 1'b0;
    assign I2C_SDA   = sda_rel_q ? 1'bz : 1'b0;
    assign tbl_index = idx_q;
    assign err_index = err_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
endmodule

// File: tb/tb_i2c_reg_init_seq.sv
// Bench for i2c_reg_init_seq: bus-level slave model plus a per-entry transaction reference model.
module tb_i2c_reg_init_seq;
    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned NUM_REGS  = 3;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned MAX_RETRY = 2;
    localparam int unsigned GAP_QTR   = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    wire scl_w, sda_w;
    pullup (scl_w);
    pullup (sda_w);
    logic slv_sda_low = 1'b0;
    logic slv_scl_low = 1'b0;
    logic slv_rst = 1'b0;
    assign sda_w = slv_sda_low ? 1'b0 : 1'bz;
    assign scl_w = slv_scl_low ? 1'b0 : 1'bz;

    logic [23:0]      tbl [NUM_REGS];
    logic [IDX_W-1:0] tbl_index, err_index;
    logic [23:0]      tbl_data;
    logic             busy, done, error;
    assign tbl_data = tbl[tbl_index];

    always #5 clk = ~clk;

    i2c_reg_init_seq #(
        .CLK_DIV(CLK_DIV), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W),
        .MAX_RETRY(MAX_RETRY), .GAP_QTR(GAP_QTR)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .I2C_SCL(scl_w), .I2C_SDA(sda_w),
        .tbl_index(tbl_index), .tbl_data(tbl_data), .busy(busy), .done(done),
        .error(error), .err_index(err_index)
    );

    // Slave: records every START..STOP transaction as (byte count, packed bytes).
    int          cap_n[$];
    logic [23:0] cap_b[$];
    int          plan_q[$];
    int          bits = 0, cur_n = 0, scl_edges = 0;
    logic [7:0]  cur_byte = 8'd0;
    logic [23:0] cur_b = 24'd0;
    logic        in_xfer = 1'b0, ack_slot = 1'b0, slv_nack = 1'b0;
    logic        prev_scl = 1'b1, prev_sda = 1'b1;

    always @(scl_w) scl_edges++;

    always @(posedge scl_w or negedge scl_w or posedge sda_w or negedge sda_w or posedge slv_rst) begin
        if (slv_rst) begin
            in_xfer = 1'b0; ack_slot = 1'b0; slv_sda_low = 1'b0;
            cap_n.delete(); cap_b.delete();
        end else if (scl_w !== prev_scl) begin
            if (scl_w === 1'b1) begin
                if (in_xfer && !ack_slot) begin
                    cur_byte = {cur_byte[6:0], sda_w === 1'b1};
                    bits++;
                end
            end else if (in_xfer) begin
                if (ack_slot) begin
                    slv_sda_low = 1'b0; ack_slot = 1'b0;
                end else if (bits == 8) begin
                    cur_b = {cur_b[15:0], cur_byte};
                    cur_n++; bits = 0; ack_slot = 1'b1;
                    slv_nack = (cap_n.size() < plan_q.size()) && (plan_q[cap_n.size()] == cur_n - 1);
                    slv_sda_low = !slv_nack;
                end
            end
        end else if (scl_w === 1'b1 && sda_w !== prev_sda) begin
            if (sda_w === 1'b0) begin
                in_xfer = 1'b1; bits = 0; cur_n = 0; cur_b = 24'd0; ack_slot = 1'b0;
            end else if (in_xfer) begin
                cap_n.push_back(cur_n); cap_b.push_back(cur_b); in_xfer = 1'b0;
            end
        end
        prev_scl = scl_w;
        prev_sda = sda_w;
    end

    int n_pass = 0, n_checks = 0;
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: each entry is tried up to MAX_RETRY+1 times; a NACK on byte k ends that try after k+1 bytes.
    int          exp_n[$];
    logic [23:0] exp_b[$];
    logic        exp_done, exp_err;
    int          exp_idx;
    task automatic build_model(input int ne, input int nbyte, input int nt);
        exp_n.delete(); exp_b.delete(); plan_q.delete();
        exp_err = 1'b0; exp_done = 1'b0;
        for (int e = 0; e < NUM_REGS; e++) begin
            for (int a = 0; a <= MAX_RETRY; a++) begin
                int nb, n;
                nb = (e == ne && a < nt) ? nbyte : -1;
                n = (nb < 0) ? 3 : nb + 1;
                plan_q.push_back(nb);
                exp_n.push_back(n);
                exp_b.push_back(tbl[e] >> (8 * (3 - n)));
                if (nb < 0) break;
                if (a == MAX_RETRY) begin
                    exp_err = 1'b1; exp_idx = e;
                    return;
                end
            end
        end
        exp_done = 1'b1; exp_idx = NUM_REGS - 1;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic reset_slave();
        @(negedge clk) slv_rst = 1'b1;
        @(negedge clk) slv_rst = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int cyc = 0;
        while (!(done || error) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_finished"}, 32'(cyc < 20000), 32'd1);
    endtask

    task automatic check_tr(input string tag, input int ci, input int ei);
        check_eq($sformatf("%s_tr%0d_len", tag, ci), cap_n[ci], exp_n[ei]);
        check_eq($sformatf("%s_tr%0d_data", tag, ci), 32'(cap_b[ci]), 32'(exp_b[ei]));
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, "_done"}, 32'(done), 32'(exp_done));
        check_eq({tag, "_error"}, 32'(error), 32'(exp_err));
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_index"}, 32'(tbl_index), 32'(exp_idx));
        if (exp_err) check_eq({tag, "_err_index"}, 32'(err_index), 32'(exp_idx));
        check_eq({tag, "_bus"}, {30'd0, scl_w, sda_w}, 32'd3);
    endtask

    task automatic run_scenario(input string tag, input int ne, input int nbyte, input int nt);
        build_model(ne, nbyte, nt);
        reset_slave();
        pulse_start();
        wait_end(tag);
        repeat (4) @(negedge clk);
        check_eq({tag, "_ntr"}, cap_n.size(), exp_n.size());
        for (int i = 0; i < cap_n.size() && i < exp_n.size(); i++) check_tr(tag, i, i);
        check_status(tag);
    endtask

    task automatic randomize_table();
        for (int i = 0; i < NUM_REGS; i++)
            tbl[i] = {7'($urandom), 1'b0, 8'($urandom), 8'($urandom)};
    endtask

    initial begin
        int cyc, k, e0;
        tbl[0] = 24'h729803; tbl[1] = 24'h720100; tbl[2] = 24'h720218;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        reset_slave();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done_err", {30'd0, done, error}, 32'd0);
        check_eq("rst_index", {tbl_index, err_index}, 32'd0);
        check_eq("rst_bus", {30'd0, scl_w, sda_w}, 32'd3);

        run_scenario("all_ack", -1, 0, 0);
        run_scenario("retry_ok", 1, 1, 2);
        run_scenario("fail_e0", 0, int'($urandom_range(0, 2)), 3);
        for (int r = 0; r < 5; r++) begin
            randomize_table();
            run_scenario($sformatf("rand%0d", r), int'($urandom_range(0, NUM_REGS - 1)),
                         int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        // Restart mid-byte of entry 1.
        build_model(-1, 0, 0);
        reset_slave();
        pulse_start();
        k = int'($urandom_range(0, 2));
        cyc = 0;
        while (!(tbl_index == 1 && in_xfer && cur_n == k && bits == 4) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rs_reach", 32'(cyc < 5000), 32'd1);
        pulse_start();
        wait_end("rs");
        check_eq("rs_ntr", cap_n.size(), NUM_REGS + 2);
        if (cap_n.size() == NUM_REGS + 2) begin
            check_tr("rs", 0, 0);
            check_eq("rs_partial_len", cap_n[1], k);
            check_eq("rs_partial_data", 32'(cap_b[1]), 32'(tbl[1] >> (8 * (3 - k))));
            for (int i = 0; i < NUM_REGS; i++) check_tr("rs", i + 2, i);
        end
        check_status("rs");

        // Reset during an ACK clock, with start raised in the same cycle.
        build_model(-1, 0, 0);
        reset_slave();
        pulse_start();
        cyc = 0;
        while (!(ack_slot && scl_w === 1'b1) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("ra_reach", 32'(cyc < 5000), 32'd1);
        @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ra_scl", 32'(scl_w), 32'd1);
        check_eq("ra_busy", 32'(busy), 32'd0);
        check_eq("ra_done_err", {30'd0, done, error}, 32'd0);
        check_eq("ra_index", {tbl_index, err_index}, 32'd0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        reset_slave();
        check_eq("ra_sda", 32'(sda_w), 32'd1);
        e0 = scl_edges;
        repeat (400) @(negedge clk);
        check_eq("ra_quiet", scl_edges - e0, 32'd0);
        check_eq("ra_idle_busy", 32'(busy), 32'd0);

`ifdef I2C_CLK_STRETCH_EN
        randomize_table();
        build_model(-1, 0, 0);
        reset_slave();
        pulse_start();
        cyc = 0;
        while (!(in_xfer && cur_n == 0 && bits == 4 && scl_w === 1'b0) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("st_reach", 32'(cyc < 5000), 32'd1);
        slv_scl_low = 1'b1;
        repeat (50) @(negedge clk);
        slv_scl_low = 1'b0;
        wait_end("st");
        repeat (4) @(negedge clk);
        check_eq("st_ntr", cap_n.size(), exp_n.size());
        for (int i = 0; i < cap_n.size() && i < exp_n.size(); i++) check_tr("st", i, i);
        check_status("st");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
